// File: rtl/alt_vipitc130_common_multi_sync.sv
// -----------------------------------------------------------------------------
// alt_vipitc130_common_multi_sync
//
// Brings a WIDTH-bit asynchronous level bus into the sync_clock domain through
// a configurable-depth flop chain. An optional glitch filter lets a new word
// through only after it has held for FILTER_CYCLES+2 samples. Per-bit
// rise/fall pulses and a word-level changed pulse are derived from data_out.
//
// Parameters:
//   CLOCKS_ARE_SAME : 1 = data_in already in sync_clock domain, chain bypassed
//   WIDTH           : bus width in bits (>=1)
//   STAGES          : synchroniser depth (>=2), unused when CLOCKS_ARE_SAME=1
//   RESET_VALUE     : value loaded into every data register on reset
//   FILTER_CYCLES   : 0 = filter off, F>0 = word must be stable (F<=255)
//
// Ports:
//   sync_clock : destination clock, all state on its rising edge
//   rst_n      : asynchronous active-low reset
//   data_in    : asynchronous level inputs
//   data_out   : synchronised (and filtered) levels
//   rise_pulse : per-bit 1-cycle pulse when a data_out bit goes 0->1
//   fall_pulse : per-bit 1-cycle pulse when a data_out bit goes 1->0
//   changed    : 1-cycle pulse when any data_out bit changed
//   stable     : filter idle (candidate == data_out == synchronised input)
// -----------------------------------------------------------------------------
module alt_vipitc130_common_multi_sync #(
    parameter int unsigned      CLOCKS_ARE_SAME = 0,
    parameter int unsigned      WIDTH           = 1,
    parameter int unsigned      STAGES          = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int unsigned      FILTER_CYCLES   = 0
) (
    input  logic             sync_clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             changed,
    output logic             stable
);

    // Synchronised input word (last chain stage, or data_in when bypassed)
    logic [WIDTH-1:0] s;
    // data_out delayed by one edge, reference for the edge detectors
    logic [WIDTH-1:0] data_out_q;

    // -------------------------------------------------------------------------
    // Synchroniser chain
    // -------------------------------------------------------------------------
    generate
        if (CLOCKS_ARE_SAME != 0) begin : g_same
            assign s = data_in;
        end else begin : g_chain
            // Only the first stage samples the asynchronous bus; the
            // synchroniser identification and the false path target it alone.
            (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name SDC_STATEMENT {set_false_path -to [get_keepers {*g_chain|stage0*}]}" *)
            logic [WIDTH-1:0] stage0;
            logic [WIDTH-1:0] stage_rest [STAGES-1];

            // First metastability-catching stage
            always_ff @(posedge sync_clock or negedge rst_n) begin
                if (!rst_n) begin
                    stage0 <= RESET_VALUE;
                end else begin
                    stage0 <= data_in;
                end
            end

            // Remaining resolution stages
            for (genvar i = 0; i < STAGES - 1; i++) begin : g_stage
                if (i == 0) begin : g_first
                    always_ff @(posedge sync_clock or negedge rst_n) begin
                        if (!rst_n) begin
                            stage_rest[i] <= RESET_VALUE;
                        end else begin
                            stage_rest[i] <= stage0;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge sync_clock or negedge rst_n) begin
                        if (!rst_n) begin
                            stage_rest[i] <= RESET_VALUE;
                        end else begin
                            stage_rest[i] <= stage_rest[i-1];
                        end
                    end
                end
            end

            assign s = stage_rest[STAGES-2];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Glitch filter (or direct pass-through)
    // -------------------------------------------------------------------------
    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            // When the chain is bypassed s follows data_in even in reset, so
            // force the reset value here to keep data_out and the pulses quiet.
            assign data_out = rst_n ? s : RESET_VALUE;
            assign stable   = 1'b1;
        end else begin : g_filt
            localparam int unsigned CW      = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

            logic [WIDTH-1:0] cand;
            logic [CW-1:0]    cnt;
            logic [WIDTH-1:0] data_out_r;

            // Candidate word, stability counter and filtered output.
            // The whole word is compared, so skewed bits settling inside the
            // window restart the count and only the final word is published.
            always_ff @(posedge sync_clock or negedge rst_n) begin
                if (!rst_n) begin
                    cand       <= RESET_VALUE;
                    cnt        <= '0;
                    data_out_r <= RESET_VALUE;
                end else if (s != cand) begin
                    cand <= s;
                    cnt  <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    // Saturated: keep rewriting the candidate (no-op once equal)
                    data_out_r <= cand;
                end
            end

            assign data_out = data_out_r;
            assign stable   = !rst_n || ((cand == data_out_r) && (s == cand));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Edge detection
    // -------------------------------------------------------------------------
    always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= RESET_VALUE;
        end else begin
            data_out_q <= data_out;
        end
    end

    // Pulses line up with the first cycle data_out shows the new value
    assign rise_pulse = data_out & ~data_out_q;
    assign fall_pulse = ~data_out & data_out_q;
    assign changed    = |(data_out ^ data_out_q);

endmodule

// File: tb/tb_alt_vipitc130_common_multi_sync.sv
module tb_alt_vipitc130_common_multi_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    int tests = 0;
    int fails = 0;

    // u0: W4 S2 F0 RV5
    logic [3:0] d0, o0, r0, f0;
    logic       c0, s0;
    // u1: W1 S3 F4 RV0
    logic [0:0] d1, o1, r1, f1;
    logic       c1, s1;
    // u2: W8 S2 F3 RV0
    logic [7:0] d2, o2, r2, f2;
    logic       c2, s2;
    // u3: W1 same clock F0 RV0
    logic [0:0] d3, o3, r3, f3;
    logic       c3, s3;
    // u4: W2 S2 F255 RV0
    logic [1:0] d4, o4, r4, f4;
    logic       c4, s4;

    alt_vipitc130_common_multi_sync #(
        .CLOCKS_ARE_SAME(0), .WIDTH(4), .STAGES(2), .RESET_VALUE(4'h5), .FILTER_CYCLES(0)
    ) u0 (
        .sync_clock(clk), .rst_n(rst_a), .data_in(d0), .data_out(o0),
        .rise_pulse(r0), .fall_pulse(f0), .changed(c0), .stable(s0)
    );

    alt_vipitc130_common_multi_sync #(
        .CLOCKS_ARE_SAME(0), .WIDTH(1), .STAGES(3), .RESET_VALUE(1'b0), .FILTER_CYCLES(4)
    ) u1 (
        .sync_clock(clk), .rst_n(rst_b), .data_in(d1), .data_out(o1),
        .rise_pulse(r1), .fall_pulse(f1), .changed(c1), .stable(s1)
    );

    alt_vipitc130_common_multi_sync #(
        .CLOCKS_ARE_SAME(0), .WIDTH(8), .STAGES(2), .RESET_VALUE(8'h00), .FILTER_CYCLES(3)
    ) u2 (
        .sync_clock(clk), .rst_n(rst_a), .data_in(d2), .data_out(o2),
        .rise_pulse(r2), .fall_pulse(f2), .changed(c2), .stable(s2)
    );

    alt_vipitc130_common_multi_sync #(
        .CLOCKS_ARE_SAME(1), .WIDTH(1), .STAGES(2), .RESET_VALUE(1'b0), .FILTER_CYCLES(0)
    ) u3 (
        .sync_clock(clk), .rst_n(rst_a), .data_in(d3), .data_out(o3),
        .rise_pulse(r3), .fall_pulse(f3), .changed(c3), .stable(s3)
    );

    alt_vipitc130_common_multi_sync #(
        .CLOCKS_ARE_SAME(0), .WIDTH(2), .STAGES(2), .RESET_VALUE(2'b00), .FILTER_CYCLES(255)
    ) u4 (
        .sync_clock(clk), .rst_n(rst_a), .data_in(d4), .data_out(o4),
        .rise_pulse(r4), .fall_pulse(f4), .changed(c4), .stable(s4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        d0 = 4'h5; d1 = 1'b0; d2 = 8'h00; d3 = 1'b1; d4 = 2'b00;
        #2;
        tick(); tick(); tick();
        tests++; if (o0 !== 4'h5) begin fails++; $display("FAIL reset_u0_out: got %0h expected 5", o0); end
        tests++; if (r0 !== 4'h0 || f0 !== 4'h0 || c0 !== 1'b0) begin fails++; $display("FAIL reset_u0_pulses: rise %0h fall %0h chg %0b expected 0", r0, f0, c0); end
        tests++; if (s0 !== 1'b1) begin fails++; $display("FAIL reset_u0_stable: got %0b expected 1", s0); end
        tests++; if (o1 !== 1'b0 || s1 !== 1'b1) begin fails++; $display("FAIL reset_u1: out %0b stable %0b expected 0/1", o1, s1); end
        tests++; if (o2 !== 8'h00 || c2 !== 1'b0) begin fails++; $display("FAIL reset_u2: out %0h chg %0b expected 0/0", o2, c2); end
        tests++; if (o3 !== 1'b0 || r3 !== 1'b0 || c3 !== 1'b0) begin fails++; $display("FAIL reset_u3_bypass: out %0b rise %0b chg %0b expected 0", o3, r3, c3); end
        tests++; if (o4 !== 2'b00 || s4 !== 1'b1) begin fails++; $display("FAIL reset_u4: out %0h stable %0b expected 0/1", o4, s4); end
        d3 = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    task automatic test_static();
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (o0 !== 4'h5 || c0 !== 1'b0 || r0 !== 4'h0 || f0 !== 4'h0) begin
                fails++; $display("FAIL static_u0 cyc%0d: out %0h chg %0b rise %0h fall %0h expected 5/0/0/0", k, o0, c0, r0, f0);
            end
        end
    endtask

    task automatic test_step();
        d0 = 4'hA;
        tick();
        tests++; if (o0 !== 4'h5 || c0 !== 1'b0) begin fails++; $display("FAIL step_edge1: out %0h chg %0b expected 5/0", o0, c0); end
        tick();
        tests++; if (o0 !== 4'hA) begin fails++; $display("FAIL step_edge2_out: got %0h expected a", o0); end
        tests++; if (r0 !== 4'hA || f0 !== 4'h5 || c0 !== 1'b1) begin fails++; $display("FAIL step_edge2_pulses: rise %0h fall %0h chg %0b expected a/5/1", r0, f0, c0); end
        tick();
        tests++; if (o0 !== 4'hA || r0 !== 4'h0 || f0 !== 4'h0 || c0 !== 1'b0) begin fails++; $display("FAIL step_edge3: out %0h rise %0h fall %0h chg %0b expected a/0/0/0", o0, r0, f0, c0); end
    endtask

    task automatic test_filter_latency();
        logic eo, er, es;
        d1 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            eo = (k >= 9);
            er = (k == 9);
            es = (k < 3) || (k >= 9);
            tests++; if (o1 !== eo || r1 !== er || c1 !== er) begin
                fails++; $display("FAIL filter_latency edge%0d: out %0b rise %0b chg %0b expected %0b/%0b/%0b", k, o1, r1, c1, eo, er, er);
            end
            tests++; if (s1 !== es) begin fails++; $display("FAIL filter_stable edge%0d: got %0b expected %0b", k, s1, es); end
        end
    endtask

    task automatic test_glitch();
        d1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            tests++; if (o1 !== 1'b1 || f1 !== 1'b0 || c1 !== 1'b0) begin
                fails++; $display("FAIL glitch edge%0d: out %0b fall %0b chg %0b expected 1/0/0", k, o1, f1, c1);
            end
            if (k == 4) begin
                tests++; if (s1 !== 1'b0) begin fails++; $display("FAIL glitch_stable_low: got %0b expected 0", s1); end
            end
            if (k == 12) begin
                tests++; if (s1 !== 1'b1) begin fails++; $display("FAIL glitch_stable_back: got %0b expected 1", s1); end
            end
            if (k == 5) d1 = 1'b1;
        end
    endtask

    task automatic test_skew();
        int nchg = 0;
        logic [7:0] eo;
        d2 = 8'h0F;
        for (int k = 1; k <= 12; k++) begin
            tick();
            eo = (k >= 8) ? 8'hFF : 8'h00;
            if (c2 === 1'b1) nchg++;
            tests++; if (o2 !== eo) begin fails++; $display("FAIL skew edge%0d: got %0h expected %0h", k, o2, eo); end
            if (k == 1) d2 = 8'hFF;
        end
        tests++; if (nchg != 1) begin fails++; $display("FAIL skew_changed_count: got %0d expected 1", nchg); end
    endtask

    task automatic test_same_clock();
        for (int k = 0; k < 6; k++) begin
            d3 = ~d3;
            #1;
            tests++; if (o3 !== d3 || c3 !== 1'b1 || r3 !== d3) begin
                fails++; $display("FAIL same_clock cyc%0d: out %0b chg %0b rise %0b expected %0b/1/%0b", k, o3, c3, r3, d3, d3);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic eo, er;
        d1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++; if (o1 !== 1'b1) begin fails++; $display("FAIL pre_reset edge%0d: got %0b expected 1", k, o1); end
        end
        #2;
        rst_b = 1'b0;
        #1;
        tests++; if (o1 !== 1'b0) begin fails++; $display("FAIL async_reset_out: got %0b expected 0", o1); end
        tests++; if (r1 !== 1'b0 || f1 !== 1'b0 || c1 !== 1'b0 || s1 !== 1'b1) begin
            fails++; $display("FAIL async_reset_pulses: rise %0b fall %0b chg %0b stable %0b expected 0/0/0/1", r1, f1, c1, s1);
        end
        d1 = 1'b1;
        tick(); tick();
        tests++; if (o1 !== 1'b0) begin fails++; $display("FAIL held_reset_out: got %0b expected 0", o1); end
        rst_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            eo = (k >= 9);
            er = (k == 9);
            tests++; if (o1 !== eo || r1 !== er) begin
                fails++; $display("FAIL post_reset edge%0d: out %0b rise %0b expected %0b/%0b", k, o1, r1, eo, er);
            end
        end
    endtask

    task automatic test_long_filter();
        logic early = 1'b0;
        d4 = 2'b11;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k < 259 && (o4 !== 2'b00 || c4 !== 1'b0)) early = 1'b1;
            if (k == 258) begin
                tests++; if (o4 !== 2'b00) begin fails++; $display("FAIL f255_256_samples: got %0h expected 0", o4); end
            end
            if (k == 259) begin
                tests++; if (o4 !== 2'b11 || r4 !== 2'b11 || c4 !== 1'b1) begin
                    fails++; $display("FAIL f255_257_samples: out %0h rise %0h chg %0b expected 3/3/1", o4, r4, c4);
                end
            end
            if (k == 260) begin
                tests++; if (o4 !== 2'b11 || r4 !== 2'b00 || c4 !== 1'b0 || s4 !== 1'b1) begin
                    fails++; $display("FAIL f255_saturate: out %0h rise %0h chg %0b stable %0b expected 3/0/0/1", o4, r4, c4, s4);
                end
            end
        end
        tests++; if (early !== 1'b0) begin fails++; $display("FAIL f255_early_update: got %0b expected 0", early); end
    endtask

    initial begin
        test_reset();
        test_static();
        test_step();
        test_filter_latency();
        test_glitch();
        test_skew();
        test_same_clock();
        test_reset_mid();
        test_long_filter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
